// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's instruction-memory handshake, pipeline control
// inputs and IF/ID-facing outputs. master = fetch stage, slave = its surroundings.
interface if_fetch_stage_if;
  logic        IMEM_Req;
  logic [31:0] IMEM_Addr;
  logic        IMEM_Ready;
  logic [31:0] IMEM_RData;
  logic        ID_Stall;
  logic        ID_IsBranch;
  logic        ID_Redirect;
  logic [31:0] ID_Target;
  logic        EX_ExceptionFlush;
  logic [31:0] EX_ExceptionVector;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PCOut;
  logic [31:0] IF_PCAdd4;
  logic        IF_Stall;
  logic        IF_IsBDS;

  modport master (
    output IMEM_Req, IMEM_Addr, IF_Instruction, IF_PCOut, IF_PCAdd4, IF_Stall, IF_IsBDS,
    input  IMEM_Ready, IMEM_RData, ID_Stall, ID_IsBranch, ID_Redirect, ID_Target,
           EX_ExceptionFlush, EX_ExceptionVector
  );

  modport slave (
    input  IMEM_Req, IMEM_Addr, IF_Instruction, IF_PCOut, IF_PCAdd4, IF_Stall, IF_IsBDS,
    output IMEM_Ready, IMEM_RData, ID_Stall, ID_IsBranch, ID_Redirect, ID_Target,
           EX_ExceptionFlush, EX_ExceptionVector
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS III instruction-fetch stage: owns the PC, single-outstanding IMEM fetch,
// holds a returned word while IF/ID is stalled, and applies delayed-slot redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic              CLK,
  input  logic              RST,
  if_fetch_stage_if.master  bus
);

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic        r_redir_pending;
  logic [31:0] r_redir_target;
  logic        r_bds_pending;

  logic [31:0] w_pc_add4;
  logic [31:0] w_next_pc;
  logic [31:0] w_id_target;
  logic [31:0] w_vector;
  logic        w_in_req;
  logic        w_valid;
  logic        w_consume;
  logic        w_id_take;
  logic        w_flush;

  assign w_pc_add4   = r_pc + 32'd4;
  assign w_id_target = bus.ID_Target & 32'hFFFF_FFFC;
  assign w_vector    = bus.EX_ExceptionVector & 32'hFFFF_FFFC;
  assign w_in_req    = (r_state == ST_REQ);
  assign w_flush     = bus.EX_ExceptionFlush;
  assign w_id_take   = bus.ID_Redirect & ~bus.ID_Stall;

  // Instruction validity and consumption for the current cycle
  always_comb begin
    w_valid = 1'b0;
    if (RST || w_flush) begin
      w_valid = 1'b0;
    end else if (w_in_req) begin
      w_valid = bus.IMEM_Ready;
    end else begin
      w_valid = 1'b1;
    end
    w_consume = w_valid & ~bus.ID_Stall;
  end

  // Next PC: flush vector beats the delay-slot redirect, which beats sequential
  always_comb begin
    w_next_pc = r_pc;
    if (w_flush) begin
      w_next_pc = w_vector;
    end else if (w_consume) begin
      if (r_redir_pending) begin
        w_next_pc = r_redir_target;
      end else if (w_id_take) begin
        w_next_pc = w_id_target;
      end else begin
        w_next_pc = w_pc_add4;
      end
    end else begin
      w_next_pc = r_pc;
    end
  end

  // Next FSM state
  always_comb begin
    w_next_state = r_state;
    if (w_flush) begin
      w_next_state = ST_REQ;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_valid && bus.ID_Stall) begin
            w_next_state = ST_HOLD;
          end else begin
            w_next_state = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (!bus.ID_Stall) begin
            w_next_state = ST_REQ;
          end else begin
            w_next_state = ST_HOLD;
          end
        end
        default: w_next_state = ST_REQ;
      endcase
    end
  end

  // PC, FSM and hold buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc       <= RESET_VECTOR;
      r_state    <= ST_REQ;
      r_hold_buf <= 32'd0;
    end else begin
      r_pc    <= w_next_pc;
      r_state <= w_next_state;
      if (w_flush) begin
        r_hold_buf <= 32'd0;
      end else if (w_in_req && w_valid && bus.ID_Stall) begin
        r_hold_buf <= bus.IMEM_RData;
      end else begin
        r_hold_buf <= r_hold_buf;
      end
    end
  end

  // Branch seen in ID before its delay slot was consumed: remember target and BDS flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_redir_pending <= 1'b0;
      r_redir_target  <= 32'd0;
      r_bds_pending   <= 1'b0;
    end else begin
      if (w_flush || w_consume) begin
        r_redir_pending <= 1'b0;
        r_bds_pending   <= 1'b0;
      end else begin
        if (w_id_take) begin
          r_redir_pending <= 1'b1;
          r_redir_target  <= w_id_target;
        end else begin
          r_redir_pending <= r_redir_pending;
        end
        if (bus.ID_IsBranch && !bus.ID_Stall) begin
          r_bds_pending <= 1'b1;
        end else begin
          r_bds_pending <= r_bds_pending;
        end
      end
    end
  end

  // Outputs are combinational so a returned word reaches IF/ID with no added latency
  always_comb begin
    bus.IMEM_Req  = ~RST & w_in_req;
    bus.IMEM_Addr = r_pc;
    bus.IF_PCOut  = r_pc;
    bus.IF_PCAdd4 = w_pc_add4;
    bus.IF_Stall  = ~w_valid;
    bus.IF_IsBDS  = w_valid & (r_bds_pending | (bus.ID_IsBranch & ~bus.ID_Stall));
    if (!w_valid) begin
      bus.IF_Instruction = 32'd0;
    end else if (w_in_req) begin
      bus.IF_Instruction = bus.IMEM_RData;
    end else begin
      bus.IF_Instruction = r_hold_buf;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs change on the falling edge,
// outputs are checked 1ns later, state advances on the rising edge.
module tb_if_fetch_stage;
  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  if_fetch_stage_if bus ();

  if_fetch_stage #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_in(input logic rdy, input logic [31:0] rdata, input logic id_stall,
                        input logic is_br, input logic redir, input logic [31:0] tgt,
                        input logic flush, input logic [31:0] vec);
    bus.IMEM_Ready         = rdy;
    bus.IMEM_RData         = rdata;
    bus.ID_Stall           = id_stall;
    bus.ID_IsBranch        = is_br;
    bus.ID_Redirect        = redir;
    bus.ID_Target          = tgt;
    bus.EX_ExceptionFlush  = flush;
    bus.EX_ExceptionVector = vec;
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_in(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.IMEM_Req); end
    n_checks++; if (bus.IF_Stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", bus.IF_Stall); end
    n_checks++; if (bus.IF_IsBDS !== 1'b0) begin n_fail++; $display("FAIL reset_bds got %b want 0", bus.IF_IsBDS); end
    n_checks++; if (bus.IF_Instruction !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.IF_Instruction); end
    n_checks++; if (bus.IMEM_Addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_addr got %h want bfc00000", bus.IMEM_Addr); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'hBFC0_0000 + 32'(4 * i);
      set_in(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      n_checks++; if (bus.IMEM_Addr !== exp_pc) begin n_fail++; $display("FAIL seq_addr[%0d] got %h want %h", i, bus.IMEM_Addr, exp_pc); end
      n_checks++; if (bus.IMEM_Req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d] got %b want 1", i, bus.IMEM_Req); end
      n_checks++; if (bus.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL seq_stall[%0d] got %b want 0", i, bus.IF_Stall); end
      n_checks++; if (bus.IF_PCOut !== exp_pc) begin n_fail++; $display("FAIL seq_pcout[%0d] got %h want %h", i, bus.IF_PCOut, exp_pc); end
      n_checks++; if (bus.IF_PCAdd4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_pcadd4[%0d] got %h want %h", i, bus.IF_PCAdd4, exp_pc + 32'd4); end
      n_checks++; if (bus.IF_Instruction !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL seq_instr[%0d] got %h want %h", i, bus.IF_Instruction, 32'h1000_0000 + 32'(i)); end
      @(negedge CLK);
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    set_in(1'b1, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      n_checks++; if (bus.IF_Stall !== 1'b1) begin n_fail++; $display("FAIL rdylow_stall[%0d] got %b want 1", i, bus.IF_Stall); end
      n_checks++; if (bus.IMEM_Addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL rdylow_addr[%0d] got %h want bfc00004", i, bus.IMEM_Addr); end
      n_checks++; if (bus.IMEM_Req !== 1'b1) begin n_fail++; $display("FAIL rdylow_req[%0d] got %b want 1", i, bus.IMEM_Req); end
      @(negedge CLK);
    end
    set_in(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL rdylow_deliver_stall got %b want 0", bus.IF_Stall); end
    n_checks++; if (bus.IF_Instruction !== 32'hAAAA_0001) begin n_fail++; $display("FAIL rdylow_deliver_instr got %h want aaaa0001", bus.IF_Instruction); end
    n_checks++; if (bus.IF_PCOut !== 32'hBFC0_0004) begin n_fail++; $display("FAIL rdylow_deliver_pc got %h want bfc00004", bus.IF_PCOut); end
    @(negedge CLK);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'hBFC0_0008) begin n_fail++; $display("FAIL rdylow_next_addr got %h want bfc00008", bus.IMEM_Addr); end
  endtask

  task automatic test_hold();
    // PC is BFC0_0008 on entry
    set_in(1'b1, 32'h2408_0005, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL hold_capture_stall got %b want 0", bus.IF_Stall); end
    n_checks++; if (bus.IF_Instruction !== 32'h2408_0005) begin n_fail++; $display("FAIL hold_capture_instr got %h want 24080005", bus.IF_Instruction); end
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      n_checks++; if (bus.IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %b want 0", i, bus.IMEM_Req); end
      n_checks++; if (bus.IF_Instruction !== 32'h2408_0005) begin n_fail++; $display("FAIL hold_instr[%0d] got %h want 24080005", i, bus.IF_Instruction); end
      n_checks++; if (bus.IF_PCOut !== 32'hBFC0_0008) begin n_fail++; $display("FAIL hold_pc[%0d] got %h want bfc00008", i, bus.IF_PCOut); end
      n_checks++; if (bus.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall[%0d] got %b want 0", i, bus.IF_Stall); end
      @(negedge CLK);
    end
    set_in(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IF_Instruction !== 32'h2408_0005) begin n_fail++; $display("FAIL hold_release_instr got %h want 24080005", bus.IF_Instruction); end
    n_checks++; if (bus.IF_PCOut !== 32'hBFC0_0008) begin n_fail++; $display("FAIL hold_release_pc got %h want bfc00008", bus.IF_PCOut); end
    @(negedge CLK);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'hBFC0_000C) begin n_fail++; $display("FAIL hold_next_addr got %h want bfc0000c", bus.IMEM_Addr); end
    n_checks++; if (bus.IMEM_Req !== 1'b1) begin n_fail++; $display("FAIL hold_next_req got %b want 1", bus.IMEM_Req); end
  endtask

  task automatic test_branch_bds();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
    @(negedge CLK);
    set_in(1'b1, 32'h1000_0003, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'h0000_0100) begin n_fail++; $display("FAIL br_addr got %h want 00000100", bus.IMEM_Addr); end
    @(negedge CLK);
    // branch at 0x100 now in ID, delay slot fetch stalled
    set_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'd0);
    n_checks++; if (bus.IF_Stall !== 1'b1) begin n_fail++; $display("FAIL br_wait_stall got %b want 1", bus.IF_Stall); end
    n_checks++; if (bus.IF_IsBDS !== 1'b0) begin n_fail++; $display("FAIL br_wait_bds got %b want 0", bus.IF_IsBDS); end
    n_checks++; if (bus.IMEM_Addr !== 32'h0000_0104) begin n_fail++; $display("FAIL br_wait_addr got %h want 00000104", bus.IMEM_Addr); end
    @(negedge CLK);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'h0000_0104) begin n_fail++; $display("FAIL br_wait2_addr got %h want 00000104", bus.IMEM_Addr); end
    @(negedge CLK);
    set_in(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IF_IsBDS !== 1'b1) begin n_fail++; $display("FAIL br_bds_flag got %b want 1", bus.IF_IsBDS); end
    n_checks++; if (bus.IF_PCOut !== 32'h0000_0104) begin n_fail++; $display("FAIL br_bds_pc got %h want 00000104", bus.IF_PCOut); end
    n_checks++; if (bus.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL br_bds_stall got %b want 0", bus.IF_Stall); end
    @(negedge CLK);
    set_in(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'h0000_0200) begin n_fail++; $display("FAIL br_target_addr got %h want 00000200", bus.IMEM_Addr); end
    n_checks++; if (bus.IF_IsBDS !== 1'b0) begin n_fail++; $display("FAIL br_target_bds got %b want 0", bus.IF_IsBDS); end
    @(negedge CLK);
  endtask

  task automatic test_flush();
    // PC is 0x204; arm a pending redirect and BDS, then flush over them
    set_in(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'd0);
    @(negedge CLK);
    set_in(1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b1, 32'h8000_0180);
    n_checks++; if (bus.IF_Stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall got %b want 1", bus.IF_Stall); end
    n_checks++; if (bus.IF_IsBDS !== 1'b0) begin n_fail++; $display("FAIL flush_bds got %b want 0", bus.IF_IsBDS); end
    @(negedge CLK);
    set_in(1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'h8000_0180) begin n_fail++; $display("FAIL flush_vec_addr got %h want 80000180", bus.IMEM_Addr); end
    n_checks++; if (bus.IF_IsBDS !== 1'b0) begin n_fail++; $display("FAIL flush_bds_cleared got %b want 0", bus.IF_IsBDS); end
    n_checks++; if (bus.IF_Instruction !== 32'h4444_4444) begin n_fail++; $display("FAIL flush_vec_instr got %h want 44444444", bus.IF_Instruction); end
    @(negedge CLK);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'h8000_0184) begin n_fail++; $display("FAIL flush_redir_dropped got %h want 80000184", bus.IMEM_Addr); end
  endtask

  task automatic test_wrap();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFF);
    @(negedge CLK);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got %h want fffffffc", bus.IMEM_Addr); end
    n_checks++; if (bus.IF_PCAdd4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pcadd4 got %h want 00000000", bus.IF_PCAdd4); end
    @(negedge CLK);
    set_in(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    n_checks++; if (bus.IMEM_Addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next_addr got %h want 00000000", bus.IMEM_Addr); end
  endtask

  task automatic test_reset_mid_fetch();
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++; if (bus.IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %b want 0", bus.IMEM_Req); end
    n_checks++; if (bus.IMEM_Addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL midrst_addr got %h want bfc00000", bus.IMEM_Addr); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_checks++; if (bus.IMEM_Req !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_req got %b want 1", bus.IMEM_Req); end
    n_checks++; if (bus.IMEM_Addr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL midrst_restart_addr got %h want bfc00000", bus.IMEM_Addr); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    @(negedge CLK);
    test_reset();
    test_sequential();
    test_ready_low();
    test_hold();
    test_branch_bds();
    test_flush();
    test_wrap();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS III pipeline.
- Owns the PC, runs a single-outstanding-request handshake to instruction memory, and tracks branch-delay-slot redirects and exception vectoring.
- Presents a fetched instruction, its PC, and PC+4 to the IF/ID pipeline register directly downstream.
- Signals "no valid instruction" through IF_Stall, which the IF/ID register turns into a bubble.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- IMEM_Req  out  1  fetch request
- IMEM_Addr  out  32  fetch address, equals PC
- IMEM_Ready  in  1  instruction returned this cycle
- IMEM_RData  in  32  returned instruction word
- ID_Stall  in  1  IF/ID holding; instruction not consumed
- ID_IsBranch  in  1  instruction in ID is a branch or jump
- ID_Redirect  in  1  branch/jump in ID is taken
- ID_Target  in  32  taken target
- EX_ExceptionFlush  in  1  exception/ERET flush
- EX_ExceptionVector  in  32  vector/EPC to fetch next
- IF_Instruction  out  32  instruction to IF/ID
- IF_PCOut  out  32  PC of IF_Instruction
- IF_PCAdd4  out  32  IF_PCOut+4
- IF_Stall  out  1  1 = no valid instruction this cycle
- IF_IsBDS  out  1  IF_Instruction is a branch delay slot

Behaviour:
- Reset (async, RST=1): PC=RESET_VECTOR; FSM=REQ; HoldBuf=0; RedirPending=0; BDSPending=0.
  - Outputs during reset: IMEM_Req=0, IF_Stall=1, IF_IsBDS=0, IF_Instruction=0.
  - First request is issued the cycle after RST deasserts.
- PC[1:0] is always 00. Low two bits of ID_Target and EX_ExceptionVector are forced to 0.
- Arithmetic: IF_PCAdd4 = PC+4, modulo 2^32 (FFFF_FFFC wraps to 0000_0000).
- FSM state REQ:
  - IMEM_Req=1, IMEM_Addr=PC.
  - If IMEM_Ready=1, the instruction is valid: IF_Instruction=IMEM_RData, IF_Stall=0 (combinational pass-through, zero added latency).
  - Valid and ID_Stall=0: instruction is consumed, PC<=NextPC, stay in REQ.
  - Valid and ID_Stall=1: capture RData into HoldBuf, go to HOLD.
  - IMEM_Ready=0: IF_Stall=1.
- FSM state HOLD:
  - IMEM_Req=0; IF_Instruction=HoldBuf; IF_Stall=0.
  - When ID_Stall=0: consumed, PC<=NextPC, go to REQ.
- IMEM is a non-pipelined slave. Req/Addr may change before Ready without side effects.
- NextPC priority:
  - EX_ExceptionFlush: vector.
  - Else redirect for the delay slot being consumed: RedirTarget if RedirPending, else ID_Target if ID_Redirect & ~ID_Stall.
  - Else PC+4.
- Redirect applies after the delay slot, never to it.
  - When ID_Redirect & ~ID_Stall and no instruction is consumed that cycle: RedirPending<=1, RedirTarget<=ID_Target.
  - Cleared when the next instruction (the BDS) is consumed.
- IF_IsBDS = ~IF_Stall & (BDSPending | (ID_IsBranch & ~ID_Stall)).
  - BDSPending<=1 when ID_IsBranch & ~ID_Stall & no consume; cleared on consume.
- EX_ExceptionFlush (overrides all, any state):
  - IF_Stall=1 and IF_IsBDS=0 that cycle.
  - Any data returned that cycle is discarded.
  - PC<=vector; RedirPending, BDSPending, HoldBuf cleared; FSM<=REQ.
- Simultaneous flush and redirect: flush wins; redirect is dropped.
- ID_Stall=1 with IF_Stall=1: fetch continues; state is unaffected by the stall.
- Reset mid-fetch: the outstanding request is abandoned; fetch restarts at RESET_VECTOR.

Test Plan:
- Reset release, Ready always 1, no stalls -> IMEM_Addr BFC0_0000, _0004, _0008 on consecutive cycles; IF_Stall=0 each cycle; IF_PCAdd4=IF_PCOut+4.
- Ready low 2 cycles at PC=BFC0_0004 -> IF_Stall=1 for 2 cycles, Addr held at _0004, then instruction delivered with IF_Stall=0.
- Ready=1 while ID_Stall=1 for 3 cycles, RData=0x2408_0005 -> HOLD state, IMEM_Req=0, IF_Instruction stays 0x2408_0005, PC unchanged; PC advances on the cycle ID_Stall drops.
- Branch at 0x100 in ID, ID_Redirect=1, target 0x200, with BDS fetch delayed by Ready=0 for 2 cycles -> 0x104 delivered with IF_IsBDS=1; next Addr 0x200.
- EX_ExceptionFlush with vector 8000_0180 in the same cycle as Ready=1 and ID_Redirect=1 -> IF_Stall=1, data dropped, pending state cleared, next Addr 8000_0180.
- PC=FFFF_FFFC -> IF_PCAdd4=0000_0000; next Addr 0000_0000.
